// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants, FSM encoding and tap-offset helper for the
//               convolution datapath (window_gen, multiplier).
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int BITS        = 9;
    localparam int KERNEL_SIZE = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit offset of tap (row, col) inside a packed row-major window
    function automatic int tap_offset(input int row, input int col,
                                      input int ksize, input int bits);
        return (row * ksize + col) * bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Circular delay line of DEPTH entries; dout is the sample
//               written DEPTH enabled steps earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int BITS  = 9,
    parameter int DEPTH = 33
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] dout
);

    localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

    logic [BITS-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_ptr;

    // The slot about to be overwritten holds the oldest sample
    assign dout = r_mem[r_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (en) begin
            r_mem[r_ptr] <= din;
            r_ptr        <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_gen
// Description : Streaming zero-padded 3x3 window generator; one window per
//               input pixel, raster order, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module window_gen
    import conv_pkg::*;
#(
    parameter int BITS        = conv_pkg::BITS,
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
)(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [BITS-1:0]                       pixel_in,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  frame_done
);

    localparam int                c_win_w    = KERNEL_SIZE * KERNEL_SIZE * BITS;
    localparam int                c_vr_w     = $clog2(IMG_HEIGHT + 1);
    localparam int                c_vc_w     = $clog2(IMG_WIDTH + 1);
    localparam logic [c_vr_w-1:0] c_last_row = c_vr_w'(IMG_HEIGHT);
    localparam logic [c_vc_w-1:0] c_last_col = c_vc_w'(IMG_WIDTH);
    localparam logic [c_vr_w-1:0] c_one_row  = c_vr_w'(1);
    localparam logic [c_vc_w-1:0] c_one_col  = c_vc_w'(1);

    state_t              r_state;
    logic [c_vr_w-1:0]   r_vr;
    logic [c_vc_w-1:0]   r_vc;
    logic                r_scan_done;
    logic [BITS-1:0]     r_hist [KERNEL_SIZE][KERNEL_SIZE-1];
    logic [c_win_w-1:0]  r_window;
    logic                r_out_valid;

    logic                w_scan;
    logic                w_real;
    logic                w_emit;
    logic                w_out_free;
    logic                w_fire;
    logic [BITS-1:0]     w_pix;
    logic [BITS-1:0]     w_lb0;
    logic [BITS-1:0]     w_lb1;
    logic [BITS-1:0]     w_col [KERNEL_SIZE];
    logic [BITS-1:0]     w_tap [KERNEL_SIZE][KERNEL_SIZE];
    logic [c_win_w-1:0]  w_window;

    assign w_scan     = (r_state == ST_RUN) && !r_scan_done;
    assign w_real     = (r_vr < c_last_row) && (r_vc < c_last_col);
    assign w_emit     = (r_vr != '0) && (r_vc != '0);
    assign w_out_free = !w_emit || !r_out_valid || out_ready;
    assign w_fire     = w_scan && (!w_real || in_valid) && w_out_free;
    assign in_ready   = w_scan && w_real && w_out_free;

    // Positions beyond the bottom/right edge inject zero padding
    assign w_pix = w_real ? pixel_in : '0;

    line_buffer #(
        .BITS  (BITS),
        .DEPTH (IMG_WIDTH + 1)
    ) u_lb0 (
        .clk  (clk),
        .rst  (reset),
        .en   (w_fire),
        .din  (w_pix),
        .dout (w_lb0)
    );

    line_buffer #(
        .BITS  (BITS),
        .DEPTH (IMG_WIDTH + 1)
    ) u_lb1 (
        .clk  (clk),
        .rst  (reset),
        .en   (w_fire),
        .din  (w_lb0),
        .dout (w_lb1)
    );

    assign w_col[0]             = w_lb1;
    assign w_col[1]             = w_lb0;
    assign w_col[KERNEL_SIZE-1] = w_pix;

    // Window = two history columns plus the incoming column; top row and
    // left column fall outside the image when the centre sits on row/col 0.
    always_comb begin
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                w_tap[i][j] = r_hist[i][j];
            end
            w_tap[i][KERNEL_SIZE-1] = w_col[i];
        end
        if (r_vr == c_one_row) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                w_tap[0][j] = '0;
            end
        end
        if (r_vc == c_one_col) begin
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                w_tap[i][0] = '0;
            end
        end
    end

    for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < KERNEL_SIZE; gj++) begin : g_col
            assign w_window[tap_offset(gi, gj, KERNEL_SIZE, BITS) +: BITS] = w_tap[gi][gj];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_vr        <= '0;
            r_vc        <= '0;
            r_scan_done <= 1'b0;
            r_out_valid <= 1'b0;
            r_window    <= '0;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                    r_hist[i][j] <= '0;
                end
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_vr        <= '0;
                        r_vc        <= '0;
                        r_scan_done <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_fire) begin
                        if (r_vc == c_last_col) begin
                            r_vc <= '0;
                            if (r_vr == c_last_row) begin
                                r_scan_done <= 1'b1;
                            end else begin
                                r_vr <= r_vr + 1'b1;
                            end
                        end else begin
                            r_vc <= r_vc + 1'b1;
                        end
                    end
                    // Leave once the final window has been taken
                    if (r_scan_done && (!r_out_valid || out_ready)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_fire) begin
                for (int i = 0; i < KERNEL_SIZE; i++) begin
                    for (int j = 0; j < KERNEL_SIZE - 2; j++) begin
                        r_hist[i][j] <= r_hist[i][j+1];
                    end
                    r_hist[i][KERNEL_SIZE-2] <= w_col[i];
                end
            end

            if (w_fire && w_emit) begin
                r_window    <= w_window;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign window_out = r_window;
    assign out_valid  = r_out_valid;
    assign frame_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_gen
// Description : Self-checking bench for window_gen on a 4x4 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_gen;

    localparam int BITS = 9;
    localparam int K    = 3;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int WW   = K * K * BITS;

    typedef logic [WW-1:0] win_t;
    typedef struct {
        int   idx;
        win_t exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [BITS-1:0] pixel_in;
    logic            in_valid;
    logic            in_ready;
    win_t            window_out;
    logic            out_valid;
    logic            out_ready;
    logic            frame_done;

    always #5 clk = ~clk;

    window_gen #(
        .BITS        (BITS),
        .KERNEL_SIZE (K),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pixel_in   (pixel_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .window_out (window_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    win_t exp_q[$];
    win_t cap[W*H];
    vec_t vecs[5];

    function automatic int pix(input int r, input int c);
        return 4 * r + c + 1;
    endfunction

    function automatic win_t mk(input int t0, input int t1, input int t2,
                                input int t3, input int t4, input int t5,
                                input int t6, input int t7, input int t8);
        int   t[9];
        win_t w;
        t = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*BITS +: BITS] = BITS'(t[k]);
        return w;
    endfunction

    // Reference: zero-padded neighbourhood of centre (r, c)
    function automatic win_t model_win(input int r, input int c);
        win_t w;
        w = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                int rr;
                int cc;
                rr = r + i - 1;
                cc = c + j - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    w[(i*K+j)*BITS +: BITS] = BITS'(pix(rr, cc));
            end
        end
        return w;
    endfunction

    task automatic check_win(input string name, input win_t act, input win_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input string tag, input bit rnd_iv, input bit rnd_or,
                             input bit do_stall, input int start_at, input int abort_at);
        int   px;
        int   wins;
        int   hs;
        int   dones;
        int   cyc;
        int   stall_left;
        int   last_acc;
        int   done_cyc;
        bit   stall_done;
        bit   finished;
        win_t held;
        px = 0; wins = 0; hs = 0; dones = 0; cyc = 0; stall_left = 0;
        last_acc = -100; done_cyc = -100; stall_done = 0; finished = 0; held = '0;
        exp_q.delete();
        for (int i = 0; i < W*H; i++) cap[i] = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(model_win(r, c));

        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (cyc < 600) begin
            in_valid = (px < W*H) && (!rnd_iv || $urandom_range(0, 2) != 0);
            pixel_in = BITS'(pix(px / W, px % W));
            if (do_stall && !stall_done && px == 7 && out_valid) begin
                stall_left = 5;
                stall_done = 1;
                held       = window_out;
            end
            if (stall_left > 0) out_ready = 1'b0;
            else                out_ready = !rnd_or || $urandom_range(0, 2) != 0;
            start = (cyc == start_at);

            @(negedge clk);
            if (stall_left > 0) begin
                check_bit({tag, "_stall_out_valid"}, out_valid, 1'b1);
                check_win({tag, "_stall_hold"}, window_out, held);
                check_bit({tag, "_stall_in_ready"}, in_ready, 1'b0);
                stall_left--;
            end
            if (in_valid && in_ready) begin
                px++;
                hs++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s_extra_window: got %h expected none", tag, window_out);
                end else begin
                    check_win($sformatf("%s_window_%0d", tag, wins), window_out, exp_q.pop_front());
                end
                if (wins < W*H) cap[wins] = window_out;
                wins++;
                last_acc = cyc;
            end
            if (frame_done) begin
                dones++;
                done_cyc = cyc;
            end
            if (abort_at >= 0 && px == abort_at) begin
                reset = 1'b1;
                #1;
                check_bit({tag, "_abort_out_valid"}, out_valid, 1'b0);
                check_bit({tag, "_abort_in_ready"}, in_ready, 1'b0);
                check_bit({tag, "_abort_frame_done"}, frame_done, 1'b0);
                check_win({tag, "_abort_window"}, window_out, '0);
                @(posedge clk); #1;
                reset    = 1'b0;
                in_valid = 1'b0;
                start    = 1'b0;
                @(negedge clk);
                check_bit({tag, "_post_reset_in_ready"}, in_ready, 1'b0);
                check_bit({tag, "_post_reset_out_valid"}, out_valid, 1'b0);
                exp_q.delete();
                return;
            end
            if (dones > 0 && cyc >= done_cyc + 4) begin
                finished = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        start     = 1'b0;

        if (!finished) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d windows expected frame_done", tag, wins);
        end
        check_int({tag, "_window_count"}, wins, W*H);
        check_int({tag, "_handshakes"}, hs, W*H);
        check_int({tag, "_frame_done_pulses"}, dones, 1);
        check_int({tag, "_done_latency"}, done_cyc - last_acc, 1);
        check_int({tag, "_queue_left"}, exp_q.size(), 0);
        if (do_stall) check_bit({tag, "_stall_seen"}, stall_done, 1'b1);
        for (int v = 0; v < 5; v++)
            check_win($sformatf("%s_table_%0d", tag, vecs[v].idx), cap[vecs[v].idx], vecs[v].exp);
    endtask

    initial begin
        vecs[0] = '{idx: 0,  exp: mk(0, 0, 0,   0, 1, 2,    0, 5, 6)};
        vecs[1] = '{idx: 3,  exp: mk(0, 0, 0,   3, 4, 0,    7, 8, 0)};
        vecs[2] = '{idx: 5,  exp: mk(1, 2, 3,   5, 6, 7,    9, 10, 11)};
        vecs[3] = '{idx: 12, exp: mk(0, 9, 10,  0, 13, 14,  0, 0, 0)};
        vecs[4] = '{idx: 15, exp: mk(11, 12, 0, 15, 16, 0,  0, 0, 0)};

        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pixel_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_bit("reset_in_ready", in_ready, 1'b0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_frame_done", frame_done, 1'b0);
        check_win("reset_window", window_out, '0);

        run_frame("base",   1'b0, 1'b0, 1'b0, -1, -1);
        run_frame("stall",  1'b0, 1'b0, 1'b1, -1, -1);
        run_frame("random", 1'b1, 1'b1, 1'b0, -1, -1);
        run_frame("abort",  1'b0, 1'b0, 1'b0, -1,  7);
        run_frame("rerun",  1'b0, 1'b0, 1'b0, -1, -1);
        run_frame("midst",  1'b0, 1'b0, 1'b0,  8, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
